// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT unsigned 8-bit products per batch and hands each batch sum
// downstream over valid/ready, with a sticky carry-out overflow flag.
module product_accumulator #(
   parameter int ACC_W = 10,
   parameter int COUNT = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic [7:0]                 prod_in,
   input  logic                       prod_valid,
   output logic                       prod_ready,
   output logic [ACC_W-1:0]           acc_out,
   output logic                       acc_ovf,
   output logic                       acc_valid,
   input  logic                       acc_ready,
   output logic [$clog2(COUNT+1)-1:0] batch_cnt
);
   localparam int CW = $clog2(COUNT + 1);
   typedef enum logic {ACCUM, DONE} state_t;
   state_t state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic ovf_q, ovf_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [ACC_W:0] sum;
   logic accept, retire, last;
   // A finished result only lets a new product in when it is retired the same cycle.
   assign prod_ready = !clear && (state_q == ACCUM || acc_ready);
   assign accept = prod_valid && prod_ready;
   assign retire = state_q == DONE && acc_ready;
   assign sum = {1'b0, acc_q} + (ACC_W + 1)'(prod_in);
   assign last = cnt_q == CW'(COUNT - 1);
   always_comb begin
      state_d = state_q;
      acc_d = acc_q;
      ovf_d = ovf_q;
      cnt_d = cnt_q;
      if (state_q == ACCUM && accept) begin
         acc_d = sum[ACC_W-1:0];
         ovf_d = ovf_q | sum[ACC_W];
         cnt_d = cnt_q + CW'(1);
         state_d = last ? DONE : ACCUM;
      end else if (retire) begin
         acc_d = accept ? ACC_W'(prod_in) : '0;
         ovf_d = 1'b0;
         cnt_d = accept ? CW'(1) : '0;
         state_d = (accept && COUNT == 1) ? DONE : ACCUM;
      end
   end
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q <= ACCUM;
         acc_q <= '0;
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         ovf_q <= ovf_d;
         cnt_q <= cnt_d;
      end
   end
   assign acc_out = acc_q;
   assign acc_ovf = ovf_q;
   assign acc_valid = state_q == DONE;
   assign batch_cnt = cnt_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: three configurations share one stimulus stream; each is checked
// against a running-sum reference model plus a vector table and hand-written corner sequences.
module tb_product_accumulator;
   logic clk = 1'b0;
   logic rst = 1'b1, clear = 1'b0, prod_valid = 1'b0, acc_ready = 1'b0;
   logic [7:0] prod_in = 8'd0;
   logic rdy_a, rdy_b, rdy_c, ovf_a, ovf_b, ovf_c, vld_a, vld_b, vld_c;
   logic [9:0] acc_a, acc_c;
   logic [7:0] acc_b;
   logic [2:0] cnt_a;
   logic [1:0] cnt_b;
   logic [0:0] cnt_c;
   logic [31:0] g_rdy[3], g_vld[3], g_acc[3], g_ovf[3], g_cnt[3];
   int n_pass = 0, n_chk = 0;
   int ws[3] = '{10, 8, 10};
   int cs[3] = '{4, 2, 1};
   typedef struct {int sum; int n;} mst_t;
   mst_t ms[3];
   logic init = 1'b0;
   typedef struct {int r, cl, pv, p, ar, ck, rdy, vld, acc, ovf, cnt;} vec_t;
   vec_t tv[$];

   always #5 clk = ~clk;

   product_accumulator #(.ACC_W(10), .COUNT(4)) u_a (
      .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in), .prod_valid(prod_valid),
      .prod_ready(rdy_a), .acc_out(acc_a), .acc_ovf(ovf_a), .acc_valid(vld_a),
      .acc_ready(acc_ready), .batch_cnt(cnt_a));
   product_accumulator #(.ACC_W(8), .COUNT(2)) u_b (
      .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in), .prod_valid(prod_valid),
      .prod_ready(rdy_b), .acc_out(acc_b), .acc_ovf(ovf_b), .acc_valid(vld_b),
      .acc_ready(acc_ready), .batch_cnt(cnt_b));
   product_accumulator #(.ACC_W(10), .COUNT(1)) u_c (
      .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in), .prod_valid(prod_valid),
      .prod_ready(rdy_c), .acc_out(acc_c), .acc_ovf(ovf_c), .acc_valid(vld_c),
      .acc_ready(acc_ready), .batch_cnt(cnt_c));

   always_comb begin
      g_rdy[0] = 32'(rdy_a); g_rdy[1] = 32'(rdy_b); g_rdy[2] = 32'(rdy_c);
      g_vld[0] = 32'(vld_a); g_vld[1] = 32'(vld_b); g_vld[2] = 32'(vld_c);
      g_acc[0] = 32'(acc_a); g_acc[1] = 32'(acc_b); g_acc[2] = 32'(acc_c);
      g_ovf[0] = 32'(ovf_a); g_ovf[1] = 32'(ovf_b); g_ovf[2] = 32'(ovf_c);
      g_cnt[0] = 32'(cnt_a); g_cnt[1] = 32'(cnt_b); g_cnt[2] = 32'(cnt_c);
   end

   // Model: true (unwrapped) batch sum and number of products taken; a batch is done at n==COUNT.
   function automatic mst_t mnext(mst_t s, int c);
      mst_t t = s;
      logic take = prod_valid && !clear && (s.n < c || acc_ready);
      if (rst || clear) return '{0, 0};
      if (s.n == c && acc_ready) t = '{0, 0};
      if (take) begin
         t.sum = t.sum + int'(prod_in);
         t.n = t.n + 1;
      end
      return t;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) ms[k] <= mnext(ms[k], cs[k]);
      if (rst) init <= 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic cyc(input int r, input int cl, input int pv, input int p, input int ar);
      @(negedge clk);
      rst = r != 0;
      clear = cl != 0;
      prod_valid = pv != 0;
      prod_in = 8'(p);
      acc_ready = ar != 0;
      #1;
      if (init) for (int k = 0; k < 3; k++) begin
         int md = 1 << ws[k];
         chk($sformatf("model%0d.prod_ready", k), g_rdy[k], (!clear && (ms[k].n < cs[k] || acc_ready)) ? 1 : 0);
         chk($sformatf("model%0d.acc_valid", k), g_vld[k], ms[k].n == cs[k] ? 1 : 0);
         chk($sformatf("model%0d.acc_out", k), g_acc[k], ms[k].sum % md);
         chk($sformatf("model%0d.acc_ovf", k), g_ovf[k], ms[k].sum >= md ? 1 : 0);
         chk($sformatf("model%0d.batch_cnt", k), g_cnt[k], ms[k].n);
      end
   endtask

   initial begin
      // r cl pv p ar ck | rdy vld acc ovf cnt  (expectations for the COUNT=4, ACC_W=10 instance)
      tv.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      tv.push_back('{0, 0, 1, 225, 1, 1, 1, 0, 0, 0, 0});
      tv.push_back('{0, 0, 1, 225, 1, 1, 1, 0, 225, 0, 1});
      tv.push_back('{0, 0, 1, 225, 1, 1, 1, 0, 450, 0, 2});
      tv.push_back('{0, 0, 1, 225, 1, 1, 1, 0, 675, 0, 3});
      tv.push_back('{0, 0, 0, 0, 1, 1, 1, 1, 900, 0, 4});
      tv.push_back('{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0});
      tv.push_back('{0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0});
      tv.push_back('{0, 0, 1, 2, 0, 1, 1, 0, 1, 0, 1});
      tv.push_back('{0, 0, 1, 3, 0, 1, 1, 0, 3, 0, 2});
      tv.push_back('{0, 0, 1, 4, 0, 1, 1, 0, 6, 0, 3});
      for (int i = 0; i < 5; i++) tv.push_back('{0, 0, 1, 9, 0, 1, 0, 1, 10, 0, 4});
      tv.push_back('{0, 0, 1, 9, 1, 1, 1, 1, 10, 0, 4});
      tv.push_back('{0, 0, 0, 0, 0, 1, 1, 0, 9, 0, 1});
      tv.push_back('{0, 1, 0, 0, 0, 1, 0, 0, 9, 0, 1});
      tv.push_back('{0, 0, 1, 10, 0, 1, 1, 0, 0, 0, 0});
      tv.push_back('{0, 0, 1, 20, 0, 1, 1, 0, 10, 0, 1});
      tv.push_back('{0, 1, 1, 50, 0, 1, 0, 0, 30, 0, 2});
      tv.push_back('{0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0});
      tv.push_back('{0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 1});
      tv.push_back('{0, 0, 1, 1, 0, 1, 1, 0, 2, 0, 2});
      tv.push_back('{0, 0, 1, 1, 0, 1, 1, 0, 3, 0, 3});
      tv.push_back('{0, 0, 0, 0, 0, 1, 0, 1, 4, 0, 4});
      tv.push_back('{1, 0, 0, 0, 0, 1, 0, 1, 4, 0, 4});
      tv.push_back('{0, 0, 1, 7, 0, 1, 1, 0, 0, 0, 0});
      tv.push_back('{0, 0, 1, 8, 0, 1, 1, 0, 7, 0, 1});
      tv.push_back('{1, 0, 1, 9, 0, 1, 1, 0, 15, 0, 2});
      tv.push_back('{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0});
      foreach (tv[i]) begin
         cyc(tv[i].r, tv[i].cl, tv[i].pv, tv[i].p, tv[i].ar);
         if (tv[i].ck != 0) begin
            chk($sformatf("vec%0d.prod_ready", i), 32'(rdy_a), tv[i].rdy);
            chk($sformatf("vec%0d.acc_valid", i), 32'(vld_a), tv[i].vld);
            chk($sformatf("vec%0d.acc_out", i), 32'(acc_a), tv[i].acc);
            chk($sformatf("vec%0d.acc_ovf", i), 32'(ovf_a), tv[i].ovf);
            chk($sformatf("vec%0d.batch_cnt", i), 32'(cnt_a), tv[i].cnt);
         end
      end
      // 8-bit accumulator wraps 200+100 to 44 with overflow; the next batch starts clean.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 1, 200, 1);
      cyc(0, 0, 1, 100, 1);
      cyc(0, 0, 0, 0, 1);
      chk("wrap.acc_valid", 32'(vld_b), 1);
      chk("wrap.acc_out", 32'(acc_b), 44);
      chk("wrap.acc_ovf", 32'(ovf_b), 1);
      cyc(0, 0, 1, 3, 1);
      cyc(0, 0, 1, 4, 1);
      cyc(0, 0, 0, 0, 0);
      chk("wrap2.acc_valid", 32'(vld_b), 1);
      chk("wrap2.acc_out", 32'(acc_b), 7);
      chk("wrap2.acc_ovf", 32'(ovf_b), 0);
      // COUNT=1 streams one result per cycle under continuous handshakes.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 1, 5, 1);
      chk("b2b.start_cnt", 32'(cnt_c), 0);
      cyc(0, 0, 1, 6, 1);
      chk("b2b.vld5", 32'(vld_c), 1);
      chk("b2b.acc5", 32'(acc_c), 5);
      cyc(0, 0, 1, 7, 1);
      chk("b2b.vld6", 32'(vld_c), 1);
      chk("b2b.acc6", 32'(acc_c), 6);
      cyc(0, 0, 0, 0, 1);
      chk("b2b.vld7", 32'(vld_c), 1);
      chk("b2b.acc7", 32'(acc_c), 7);
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++)
         cyc(int'($urandom_range(0, 49) == 0), int'($urandom_range(0, 24) == 0),
             int'($urandom_range(0, 9) < 7), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 9) < 6));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
